// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a registered carry.
// Flags and result update only when the last digit completes.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] so,
    output logic             co,
    output logic             ov,
    output logic             z
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_fin;
    logic             a_msb;
    logic             b_msb;
    logic             cy;
    logic [CW-1:0]    k;
    logic [DIGIT:0]   dsum;

    assign busy = (state == RUN);
    assign last = (k == CW'(STEPS - 1));

    assign dsum = {1'b0, a_sh[DIGIT-1:0]}
                + {1'b0, b_sh[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, cy};

    // Result fills from the top; after STEPS digits it is fully aligned.
    assign res_fin = (res_q >> DIGIT)
                   | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res_q <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cy    <= 1'b0;
            k     <= '0;
            done  <= 1'b0;
            so    <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
            z     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= sub ? ~b : b;
                a_msb <= a[WIDTH-1];
                b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                cy    <= sub ? ~ci : ci;
                res_q <= '0;
                k     <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> DIGIT;
                b_sh  <= b_sh >> DIGIT;
                cy    <= dsum[DIGIT];
                res_q <= res_fin;
                k     <= k + 1'b1;
                if (last) begin
                    done <= 1'b1;
                    so   <= res_fin;
                    co   <= dsum[DIGIT];
                    ov   <= (a_msb == b_msb) && (res_fin[WIDTH-1] != a_msb);
                    z    <= (res_fin == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and sweep bench for serial_adder, WIDTH=8 with DIGIT 1/2/4/8.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       busy_v [4];
    logic       done_v [4];
    logic [7:0] so_v   [4];
    logic       co_v   [4];
    logic       ov_v   [4];
    logic       z_v    [4];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .start(start),
            .sub  (sub),
            .a    (a),
            .b    (b),
            .ci   (ci),
            .busy (busy_v[g]),
            .done (done_v[g]),
            .so   (so_v[g]),
            .co   (co_v[g]),
            .ov   (ov_v[g]),
            .z    (z_v[g])
        );
    end

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_,
                            input logic tci, input logic tsub);
        @(negedge clk);
        a = ta; b = tb_; ci = tci; sub = tsub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for done on the DIGIT=2 instance; lat=-1 on timeout.
    task automatic wait_done(output int lat, output int bc);
        lat = -1;
        bc  = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy_v[1]) bc++;
            @(posedge clk);
            #1;
            if (done_v[1]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0;
        a = 8'h00; b = 8'h00; ci = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy_v[1] !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_v[1]); end
        total++; if (done_v[1] !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done_v[1]); end
        total++; if (so_v[1] !== 8'h00) begin bad++; $display("FAIL rst_so got=%h exp=00", so_v[1]); end
        total++; if ({co_v[1], ov_v[1], z_v[1]} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b%b%b exp=000", co_v[1], ov_v[1], z_v[1]); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        int lat, bc;
        start_op(8'h5A, 8'h33, 1'b0, 1'b0);
        wait_done(lat, bc);
        total++; if (lat !== 4) begin bad++; $display("FAIL add_lat got=%0d exp=4", lat); end
        total++; if (bc !== 4) begin bad++; $display("FAIL add_busy_len got=%0d exp=4", bc); end
        total++; if (busy_v[1] !== 1'b0) begin bad++; $display("FAIL add_busy_end got=%b exp=0", busy_v[1]); end
        total++; if (so_v[1] !== 8'h8D) begin bad++; $display("FAIL add_so got=%h exp=8d", so_v[1]); end
        total++; if ({co_v[1], ov_v[1], z_v[1]} !== 3'b010) begin bad++; $display("FAIL add_flags got=%b%b%b exp=010", co_v[1], ov_v[1], z_v[1]); end
        @(posedge clk);
        #1;
        total++; if (done_v[1] !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b exp=0", done_v[1]); end
    endtask

    task automatic test_wrap;
        int lat, bc;
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bc);
        total++; if (lat !== 4) begin bad++; $display("FAIL wrap_lat got=%0d exp=4", lat); end
        total++; if (so_v[1] !== 8'h00) begin bad++; $display("FAIL wrap_so got=%h exp=00", so_v[1]); end
        total++; if ({co_v[1], ov_v[1], z_v[1]} !== 3'b101) begin bad++; $display("FAIL wrap_flags got=%b%b%b exp=101", co_v[1], ov_v[1], z_v[1]); end
    endtask

    task automatic test_sub;
        int lat, bc;
        start_op(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done(lat, bc);
        total++; if (so_v[1] !== 8'hF0) begin bad++; $display("FAIL sub1_so got=%h exp=f0", so_v[1]); end
        total++; if ({co_v[1], ov_v[1], z_v[1]} !== 3'b000) begin bad++; $display("FAIL sub1_flags got=%b%b%b exp=000", co_v[1], ov_v[1], z_v[1]); end
        start_op(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(lat, bc);
        total++; if (so_v[1] !== 8'h7F) begin bad++; $display("FAIL sub2_so got=%h exp=7f", so_v[1]); end
        total++; if ({co_v[1], ov_v[1], z_v[1]} !== 3'b110) begin bad++; $display("FAIL sub2_flags got=%b%b%b exp=110", co_v[1], ov_v[1], z_v[1]); end
        start_op(8'h05, 8'h05, 1'b1, 1'b1);
        wait_done(lat, bc);
        total++; if (so_v[1] !== 8'hFF) begin bad++; $display("FAIL sub3_so got=%h exp=ff", so_v[1]); end
        total++; if ({co_v[1], z_v[1]} !== 2'b00) begin bad++; $display("FAIL sub3_flags got=%b%b exp=00", co_v[1], z_v[1]); end
        start_op(8'h05, 8'h05, 1'b0, 1'b1);
        wait_done(lat, bc);
        total++; if (so_v[1] !== 8'h00) begin bad++; $display("FAIL sub4_so got=%h exp=00", so_v[1]); end
        total++; if ({co_v[1], ov_v[1], z_v[1]} !== 3'b101) begin bad++; $display("FAIL sub4_flags got=%b%b%b exp=101", co_v[1], ov_v[1], z_v[1]); end
    endtask

    task automatic test_handshake;
        int lat, bc;
        start_op(8'h11, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1; ci = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        total++; if (lat !== 3) begin bad++; $display("FAIL hs_lat got=%0d exp=3", lat); end
        total++; if (bc !== 3) begin bad++; $display("FAIL hs_busy_len got=%0d exp=3", bc); end
        total++; if (so_v[1] !== 8'h33) begin bad++; $display("FAIL hs_so got=%h exp=33", so_v[1]); end
        total++; if ({co_v[1], ov_v[1], z_v[1]} !== 3'b000) begin bad++; $display("FAIL hs_flags got=%b%b%b exp=000", co_v[1], ov_v[1], z_v[1]); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        start_op(8'h40, 8'h40, 1'b0, 1'b0);
        wait_done(lat, bc);
        total++; if (so_v[1] !== 8'h80 || ov_v[1] !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%b exp=80/1", so_v[1], ov_v[1]); end
        start_op(8'h01, 8'h02, 1'b0, 1'b0);
        total++; if (busy_v[1] !== 1'b1 || done_v[1] !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b%b exp=10", busy_v[1], done_v[1]); end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            total++; if (so_v[1] !== 8'h80 || done_v[1] !== 1'b0) begin bad++; $display("FAIL b2b_hold%0d got=%h/%b exp=80/0", i, so_v[1], done_v[1]); end
        end
        @(posedge clk);
        #1;
        total++; if (done_v[1] !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done_v[1]); end
        total++; if (so_v[1] !== 8'h03 || ov_v[1] !== 1'b0) begin bad++; $display("FAIL b2b_second got=%h/%b exp=03/0", so_v[1], ov_v[1]); end
    endtask

    task automatic test_reset_mid;
        int lat, bc, seen;
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0) begin bad++; $display("FAIL mid_rst_hs got=%b%b exp=00", busy_v[1], done_v[1]); end
        total++; if (so_v[1] !== 8'h00) begin bad++; $display("FAIL mid_rst_so got=%h exp=00", so_v[1]); end
        total++; if ({co_v[1], ov_v[1], z_v[1]} !== 3'b000) begin bad++; $display("FAIL mid_rst_flags got=%b%b%b exp=000", co_v[1], ov_v[1], z_v[1]); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done_v[1]) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_rst_nodone got=%0d exp=0", seen); end
        start_op(8'h7F, 8'h00, 1'b1, 1'b0);
        wait_done(lat, bc);
        total++; if (lat !== 4) begin bad++; $display("FAIL post_rst_lat got=%0d exp=4", lat); end
        total++; if (so_v[1] !== 8'h80) begin bad++; $display("FAIL post_rst_so got=%h exp=80", so_v[1]); end
        total++; if ({co_v[1], ov_v[1], z_v[1]} !== 3'b010) begin bad++; $display("FAIL post_rst_flags got=%b%b%b exp=010", co_v[1], ov_v[1], z_v[1]); end
    endtask

    task automatic test_sweep;
        logic [7:0] ra, rb, bb, eso;
        logic       rci, rsub, cc, eco, eov, ez;
        logic [8:0] full;
        int         lat [4];
        repeat (10) @(posedge clk);
        for (int n = 0; n < 12; n++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rci  = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            bb   = rsub ? ~rb : rb;
            cc   = rsub ? ~rci : rci;
            full = {1'b0, ra} + {1'b0, bb} + {8'h00, cc};
            eso  = full[7:0];
            eco  = full[8];
            eov  = (ra[7] == bb[7]) && (eso[7] != ra[7]);
            ez   = (eso == 8'h00);
            for (int g = 0; g < 4; g++) lat[g] = -1;
            start_op(ra, rb, rci, rsub);
            for (int c = 1; c <= 12; c++) begin
                @(posedge clk);
                #1;
                for (int g = 0; g < 4; g++)
                    if (done_v[g] && lat[g] < 0) lat[g] = c;
            end
            for (int g = 0; g < 4; g++) begin
                total++; if (lat[g] !== (8 >> g)) begin bad++; $display("FAIL sweep%0d_d%0d_lat got=%0d exp=%0d", n, 1 << g, lat[g], 8 >> g); end
                total++; if ({so_v[g], co_v[g], ov_v[g], z_v[g]} !== {eso, eco, eov, ez}) begin bad++; $display("FAIL sweep%0d_d%0d_res got=%h/%b%b%b exp=%h/%b%b%b", n, 1 << g, so_v[g], co_v[g], ov_v[g], z_v[g], eso, eco, eov, ez); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_wrap;
        test_sub;
        test_handshake;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
